// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver for the iCESugar-nano PMOD USB-serial adapter.
//
// The asynchronous rx line is brought into the clk domain through a two-flop
// synchronizer and then oversampled by a baud counter. A start bit is
// qualified at its middle, each data bit and the stop bit are sampled at
// their middles, and a correctly framed byte is published on data_read with
// a one-clock valid_byte strobe. A low stop bit raises the error level, which
// holds until the next start bit is detected.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   reset      in   1  synchronous, active-high reset
//   rx         in   1  serial data in, idle high, asynchronous to clk
//   tx         out  1  serial data out, held idle (1)
//   cts        in   1  CTS# from adapter, sampled but not used
//   rts        out  1  RTS# to adapter, active-low: 0 = ready to receive
//   data_read  out  8  last correctly framed byte
//   valid_byte out  1  one-clock strobe: data_read just updated
//   error      out  1  framing error level
//   debug      out  8  {state[2:0], bit_idx[2:0], rx_sync, error}
// ----------------------------------------------------------------------------
module uart_rx #(
   parameter int CLKS_PER_BIT = 104,
   parameter int DATA_BITS    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       tx,
   input  logic       cts,
   output logic       rts,
   output logic [7:0] data_read,
   output logic       valid_byte,
   output logic       error,
   output logic [7:0] debug
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   // Sample points inside one bit period, counted from the state entry.
   localparam logic [CNT_W-1:0] HALF_PT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_PT  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   state_t           state_r, state_next_s;
   logic [CNT_W-1:0] clk_cnt_r, clk_cnt_next_s;
   logic [2:0]       bit_idx_r, bit_idx_next_s;
   logic [7:0]       shreg_r, shreg_next_s;
   logic [7:0]       data_read_r, data_read_next_s;
   logic             valid_r, valid_next_s;
   logic             error_r, error_next_s;
   logic             rts_r;
   logic             sync1_r, sync2_r;
   logic             cts_unused_r;
   logic             rx_sync_s;

   assign rx_sync_s = sync2_r;

   // Two-flop synchronizer for rx; idle-high so reset looks like a quiet line.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= rx;
         sync2_r <= sync1_r;
      end
   end

   // CTS# is captured for completeness; there is no transmitter to gate.
   always_ff @(posedge clk) begin
      if (reset) begin
         cts_unused_r <= 1'b1;
      end else begin
         cts_unused_r <= cts;
      end
   end

   // Next-state, baud counter, shift register and output-update logic.
   always_comb begin
      state_next_s     = state_r;
      clk_cnt_next_s   = '0;
      bit_idx_next_s   = bit_idx_r;
      shreg_next_s     = shreg_r;
      data_read_next_s = data_read_r;
      valid_next_s     = 1'b0;
      error_next_s     = error_r;

      case (state_r)
         IDLE: begin
            if (!rx_sync_s) begin
               state_next_s = START;
               error_next_s = 1'b0;
            end else begin
               state_next_s = IDLE;
            end
         end

         START: begin
            // Re-check the line half a bit later to reject short glitches.
            if (clk_cnt_r == HALF_PT) begin
               if (!rx_sync_s) begin
                  state_next_s   = DATA;
                  bit_idx_next_s = 3'd0;
               end else begin
                  state_next_s = IDLE;
               end
            end else begin
               clk_cnt_next_s = clk_cnt_r + CNT_W'(1);
            end
         end

         DATA: begin
            // Counting started mid start bit, so full-bit points land mid data bit.
            if (clk_cnt_r == FULL_PT) begin
               shreg_next_s[bit_idx_r] = rx_sync_s;
               if (bit_idx_r == LAST_BIT) begin
                  state_next_s   = STOP;
                  bit_idx_next_s = 3'd0;
               end else begin
                  bit_idx_next_s = bit_idx_r + 3'd1;
               end
            end else begin
               clk_cnt_next_s = clk_cnt_r + CNT_W'(1);
            end
         end

         STOP: begin
            if (clk_cnt_r == FULL_PT) begin
               if (rx_sync_s) begin
                  data_read_next_s = shreg_r;
                  valid_next_s     = 1'b1;
                  error_next_s     = 1'b0;
                  state_next_s     = IDLE;
               end else begin
                  error_next_s = 1'b1;
                  state_next_s = BREAK;
               end
            end else begin
               clk_cnt_next_s = clk_cnt_r + CNT_W'(1);
            end
         end

         BREAK: begin
            // A line held low must not be taken as a new start bit.
            if (rx_sync_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = BREAK;
            end
         end

         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         clk_cnt_r   <= '0;
         bit_idx_r   <= 3'd0;
         shreg_r     <= 8'h00;
         data_read_r <= 8'h00;
         valid_r     <= 1'b0;
         error_r     <= 1'b0;
         rts_r       <= 1'b1;
      end else begin
         state_r     <= state_next_s;
         clk_cnt_r   <= clk_cnt_next_s;
         bit_idx_r   <= bit_idx_next_s;
         shreg_r     <= shreg_next_s;
         data_read_r <= data_read_next_s;
         valid_r     <= valid_next_s;
         error_r     <= error_next_s;
         rts_r       <= (state_next_s != IDLE);
      end
   end

   assign tx         = 1'b1;
   assign rts        = rts_r;
   assign data_read  = data_read_r;
   assign valid_byte = valid_r;
   assign error      = error_r;
   assign debug      = {state_r, bit_idx_r, rx_sync_s, error_r};

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx with CLKS_PER_BIT = 52
// (2-unit clock, 104-unit bits). Good frames push their byte onto a
// scoreboard queue; a negedge monitor pops and compares on each strobe.
// ----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CPB = 52;

   logic       clk;
   logic       reset;
   logic       rx;
   logic       tx;
   logic       cts;
   logic       rts;
   logic [7:0] data_read;
   logic       valid_byte;
   logic       error;
   logic [7:0] debug;

   int         vectors;
   int         miscompares;
   int         strobe_cnt;
   int         exp_strobes;
   logic       prev_valid;
   logic       err_after_start;
   logic [7:0] exp_q[$];

   uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .tx         (tx),
      .cts        (cts),
      .rts        (rts),
      .data_read  (data_read),
      .valid_byte (valid_byte),
      .error      (error),
      .debug      (debug)
   );

   initial clk = 1'b0;
   always #1 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors = vectors + 1;
      if (obs !== exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: every strobe must match the oldest queued byte.
   always @(negedge clk) begin
      if (valid_byte) begin
         strobe_cnt = strobe_cnt + 1;
         check("strobe_width", {31'd0, prev_valid}, 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", 32'd1, 32'd0);
         end else begin
            check("data_read", {24'd0, data_read}, {24'd0, exp_q.pop_front()});
         end
      end
      prev_valid = valid_byte;
   end

   task automatic hold_bit(input logic v);
      rx = v;
      cts = 1'($urandom_range(0, 1));
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_ok);
      hold_bit(1'b0);
      err_after_start = error;
      for (int i = 0; i < 8; i++) begin
         hold_bit(d[i]);
      end
      if (stop_ok) begin
         exp_q.push_back(d);
         exp_strobes = exp_strobes + 1;
      end
      hold_bit(stop_ok);
      rx = 1'b1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      strobe_cnt  = 0;
      exp_strobes = 0;
      prev_valid  = 1'b0;
      err_after_start = 1'b0;
      rx    = 1'b1;
      cts   = 1'b1;
      reset = 1'b1;

      // Reset behaviour.
      repeat (2) @(negedge clk);
      check("rst_rts", {31'd0, rts}, 32'd1);
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_data", {24'd0, data_read}, 32'h00);
      check("rst_valid", {31'd0, valid_byte}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_rts", {31'd0, rts}, 32'd0);
      check("idle_debug", {24'd0, debug}, 32'h02);

      // Single good frame.
      send_frame(8'hAA, 1'b1);
      check("aa_qempty", exp_q.size(), 32'd0);
      check("aa_error", {31'd0, error}, 32'd0);
      check("aa_tx", {31'd0, tx}, 32'd1);

      // Back-to-back frames, single stop bit.
      send_frame(8'h55, 1'b1);
      send_frame(8'h0F, 1'b1);
      check("b2b_qempty", exp_q.size(), 32'd0);
      check("b2b_data", {24'd0, data_read}, 32'h0F);

      // Framing error: stop bit low, then line released.
      send_frame(8'h3C, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      check("ferr_error", {31'd0, error}, 32'd1);
      check("ferr_data", {24'd0, data_read}, 32'h0F);
      check("ferr_state", {29'd0, debug[7:5]}, 32'd0);
      check("ferr_strobes", strobe_cnt, exp_strobes);

      // Next good frame clears the error at its start bit.
      send_frame(8'h81, 1'b1);
      check("clr_err_start", {31'd0, err_after_start}, 32'd0);
      check("clr_qempty", exp_q.size(), 32'd0);
      check("clr_data", {24'd0, data_read}, 32'h81);
      check("clr_error", {31'd0, error}, 32'd0);

      // Short glitch (10 clocks) is rejected.
      rx = 1'b0;
      repeat (10) @(negedge clk);
      rx = 1'b1;
      repeat (4 * CPB) @(negedge clk);
      check("glitch_strobes", strobe_cnt, exp_strobes);
      check("glitch_error", {31'd0, error}, 32'd0);
      check("glitch_state", {29'd0, debug[7:5]}, 32'd0);

      // Reset in the middle of the data bits aborts the frame.
      hold_bit(1'b0);
      hold_bit(1'b0);
      hold_bit(1'b1);
      hold_bit(1'b0);
      repeat (CPB / 4) @(negedge clk);
      check("mid_state_data", {29'd0, debug[7:5]}, 32'd2);
      rx = 1'b1;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("mid_rst_rts", {31'd0, rts}, 32'd1);
      check("mid_rst_state", {29'd0, debug[7:5]}, 32'd0);
      reset = 1'b0;
      repeat (12 * CPB) @(negedge clk);
      check("abort_strobes", strobe_cnt, exp_strobes);
      check("abort_error", {31'd0, error}, 32'd0);
      check("abort_data", {24'd0, data_read}, 32'h00);

      send_frame(8'hC3, 1'b1);
      repeat (CPB) @(negedge clk);
      check("c3_qempty", exp_q.size(), 32'd0);
      check("c3_data", {24'd0, data_read}, 32'hC3);
      check("total_strobes", strobe_cnt, exp_strobes);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver for the iCESugar-nano PMOD USB-serial adapter.
- Oversamples the asynchronous `rx` line with the system clock and delivers each received byte on `data_read`, with a one-cycle `valid_byte` strobe.
- Flags framing errors, drives the adapter's active-low RTS# flow-control line and exposes an 8-bit debug vector for the LED PMOD.
- Receive-only: `tx` is held idle.

Parameters:
- CLKS_PER_BIT, 104, system clocks per UART bit (12 MHz / 115200 baud); must be >= 4. Benches with a 2-time-unit clock and 104-unit bits use 52.
- DATA_BITS, 8, data bits per frame (LSB first); `data_read` width is fixed at 8, so only 8 is supported.

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-high reset
- rx  input  1  serial data in, idle high, asynchronous to clk
- tx  output  1  serial data out; constant 1 (idle)
- cts  input  1  CTS# from adapter, active-low; sampled but unused (no transmitter)
- rts  output  1  RTS# to adapter, active-low: 0 = ready to receive
- data_read  output  8  last correctly framed byte
- valid_byte  output  1  one-clock strobe: data_read just updated
- error  output  1  framing error flag
- debug  output  8  {state[2:0], bit_idx[2:0], rx_sync, error}

Behaviour:
- Reset (synchronous, active-high) and its outputs:
  - Sampled on the rising clk edge; while high, all registers clear.
  - state=IDLE, counters=0, data_read=8'h00, valid_byte=0, error=0.
  - rts=1 while reset is high, tx=1, sync flops=1.
  - Reset mid-frame aborts the frame with no strobe and no error.
- Synchronizer: rx passes through two flops; rx_sync is the second flop. All decisions use rx_sync.
- Baud counter:
  - clk_cnt counts 0..CLKS_PER_BIT-1 and is cleared on every state change.
  - Half-bit point: clk_cnt == CLKS_PER_BIT/2 - 1 (integer division).
  - Full-bit point: clk_cnt == CLKS_PER_BIT-1.
- FSM:
  - IDLE: rts=0. When rx_sync==0 (falling edge), go to START and clear error.
  - START: at the half-bit point, if rx_sync==0 go to DATA with bit_idx=0; else treat as a glitch and return to IDLE.
  - DATA: at each full-bit point (the middle of the data bit), shift rx_sync into shreg[bit_idx] and increment bit_idx. After bit 7 is sampled, go to STOP.
  - STOP: at the full-bit point (mid stop bit):
    - If rx_sync==1: data_read<=shreg, valid_byte<=1 for exactly one clock, error<=0, go to IDLE.
    - If rx_sync==0: error<=1, data_read unchanged, no strobe, go to BREAK.
  - BREAK: wait until rx_sync==1, then go to IDLE. Line-held-low does not restart.
- rts=1 in START/DATA/STOP/BREAK and during reset.
- Latency: valid_byte rises 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks (±1) after the rx falling edge, i.e. mid stop bit. The receiver can accept a new start bit the cycle after valid_byte.
- error is a level: set on framing failure, held until the next start bit is detected.
- Back-to-back frames with a single stop bit must be received without loss.
- data_read holds its value between frames.
- cts has no effect on any output.

Test Plan:
- Reset held 2 cycles, rx=1 -> data_read=00, valid_byte=0, error=0, tx=1, rts=1 during reset, rts=0 after.
- CLKS_PER_BIT=52: start bit, data bits 0,1,0,1,0,1,0,1 (LSB first), stop=1, each 52 clocks -> one valid_byte pulse near mid stop bit, data_read=8'hAA, error=0.
- Two back-to-back frames 0x55 then 0x0F -> two single-cycle strobes, data_read=55 then 0F.
- Frame 0x3C with stop bit forced 0, then line high -> no strobe, error=1, data_read keeps previous value. The next good frame 0x81 clears error at its start bit and yields data_read=81.
- rx low pulse of 10 clocks (< half bit) -> returns to IDLE, no strobe, no error.
- Reset asserted mid-DATA, then a full frame 0xC3 -> no strobe from the aborted frame, data_read=C3 after the new frame.
